// File: rtl/stp_rx_ctrl.sv
// Receive sequencer for a serial-to-parallel shift register: finds the start
// bit, strobes the SR once per data bit at mid-bit, checks the stop bit and
// captures the frame with ready/overrun/framing status.
module stp_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic                 shift_enable,
  input  logic [DATA_BITS-1:0] sr_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  input  logic                 data_read,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_C = CW'(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_BIT_C = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_CHK,
    S_DATA,
    S_STOP,
    S_LOAD
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cyc_cnt, cyc_cnt_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic          prev_line;
  logic          shift_nx, fe_nx, ready_nx, ovr_nx, load;

  // In START_CHK cyc_cnt equals the cycle number since the falling edge;
  // in DATA/STOP it is that number minus HALF, modulo CLKS_PER_BIT.
  always_comb begin
    state_nx   = state;
    cyc_cnt_nx = cyc_cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = 1'b0;
    fe_nx      = framing_error;
    ready_nx   = data_ready;
    ovr_nx     = overrun_error;
    load       = 1'b0;
    if (data_read) begin
      ready_nx = 1'b0;
      ovr_nx   = 1'b0;
    end
    case (state)
      S_IDLE: begin
        cyc_cnt_nx = '0;
        if (prev_line && !serial_in) begin
          state_nx   = S_START_CHK;
          cyc_cnt_nx = CW'(1);
        end
      end
      S_START_CHK: begin
        if (cyc_cnt == HALF_C) begin
          if (!serial_in) begin
            state_nx   = S_DATA;
            cyc_cnt_nx = CW'(1);
            bit_cnt_nx = '0;
            fe_nx      = 1'b0;
          end else begin
            state_nx   = S_IDLE;
            cyc_cnt_nx = '0;
          end
        end
      end
      S_DATA: begin
        // Pulse is registered, so it is raised one cycle before the mid-bit.
        if (cyc_cnt == LAST_C) begin
          shift_nx   = 1'b1;
          cyc_cnt_nx = '0;
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT_C) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (cyc_cnt == FULL_C) begin
          cyc_cnt_nx = '0;
          if (serial_in) begin
            state_nx = S_LOAD;
          end else begin
            state_nx = S_IDLE;
            fe_nx    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load       = 1'b1;
        ready_nx   = 1'b1;
        cyc_cnt_nx = '0;
        state_nx   = S_IDLE;
        if (data_ready && !data_read) ovr_nx = 1'b1;
      end
      default: begin
        state_nx   = S_IDLE;
        cyc_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      prev_line     <= 1'b1;
      shift_enable  <= 1'b0;
      busy          <= 1'b0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
      rx_data       <= '1;
    end else begin
      state         <= state_nx;
      cyc_cnt       <= cyc_cnt_nx;
      bit_cnt       <= bit_cnt_nx;
      prev_line     <= serial_in;
      shift_enable  <= shift_nx;
      busy          <= (state_nx != S_IDLE);
      data_ready    <= ready_nx;
      overrun_error <= ovr_nx;
      framing_error <= fe_nx;
      if (load) rx_data <= sr_data;
    end
  end

endmodule

// File: tb/tb_stp_rx_ctrl.sv
// Frame-level bench for stp_rx_ctrl: a driver serialises frames, a frame-level
// model predicts each frame's outcome, and a monitor checks it when busy drops.
module tb_stp_rx_ctrl;

  localparam int DB   = 8;
  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;
  localparam int DUR_GOOD = HALF + (DB + 1) * CPB + 1;
  localparam int DUR_BAD  = HALF + (DB + 1) * CPB;
  localparam int K_GOOD = 0, K_BAD = 1, K_GLITCH = 2;

  // clock / reset
  logic          tb_clk = 1'b0;
  logic          rst = 1'b1;
  logic          serial_in = 1'b1;
  logic          data_read = 1'b0;
  logic          shift_enable, data_ready, overrun_error, framing_error, busy;
  logic [DB-1:0] rx_data;
  logic [DB-1:0] sr = '0;

  always #5 tb_clk = ~tb_clk;

  stp_rx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .sr_data      (sr),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .data_read    (data_read),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  // Shift register being sequenced: new bits enter at the MSB.
  always @(posedge tb_clk) if (shift_enable) sr <= {serial_in, sr[DB-1:1]};

  // scoreboard
  typedef struct packed {
    logic [15:0]   dur;
    logic [7:0]    npulse;
    logic [DB-1:0] data;
    logic          ready;
    logic          ovr;
    logic          fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   stray = 0;

  // frame-level reference state
  logic [DB-1:0] m_rx = '1;
  logic          m_ready = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: times each busy window and checks the outcome when it closes
  int tracking = 0;
  int dur = 0;
  int npulse = 0;

  always @(negedge tb_clk) begin
    if (rst) begin
      tracking = 0;
    end else begin
      if (busy && tracking == 0) begin
        tracking = 1;
        dur = 0;
        npulse = 0;
      end
      if (tracking != 0) begin
        if (busy) begin
          dur++;
          if (shift_enable) begin
            npulse++;
            check("pulse_time", 32'(dur), 32'(HALF + npulse * CPB));
          end
        end else begin
          tracking = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: frame ended with dur %0d, nothing expected", dur);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("busy_cycles", 32'(dur), 32'(e.dur));
            check("pulse_count", 32'(npulse), 32'(e.npulse));
            check("rx_data", 32'(rx_data), 32'(e.data));
            check("data_ready", 32'(data_ready), 32'(e.ready));
            check("overrun_error", 32'(overrun_error), 32'(e.ovr));
            check("framing_error", 32'(framing_error), 32'(e.fe));
          end
        end
      end else if (shift_enable) begin
        stray++;
      end
    end
  end

  // driver tasks
  function automatic logic line_bit(input int kind, input logic [DB-1:0] d, input int c);
    int b;
    b = c / CPB;
    if (kind == K_GLITCH || b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    return (kind == K_GOOD);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_shift"}, 32'(shift_enable), 32'(0));
    check({tag, "_ready"}, 32'(data_ready), 32'(0));
    check({tag, "_ovr"}, 32'(overrun_error), 32'(0));
    check({tag, "_fe"}, 32'(framing_error), 32'(0));
    check({tag, "_rx"}, 32'(rx_data), 32'(8'hFF));
  endtask

  task automatic send_frame(input int kind, input logic [DB-1:0] d, input int abort_at,
                            input int glen, input int gap);
    int   total;
    exp_t e;
    total = (kind == K_GLITCH) ? glen : (DB + 2) * CPB;
    if (abort_at >= total) begin
      case (kind)
        K_GOOD: begin
          if (m_ready) m_ovr = 1'b1;
          m_rx = d;
          m_ready = 1'b1;
          m_fe = 1'b0;
        end
        K_BAD: m_fe = 1'b1;
        default: ;
      endcase
      e.dur    = 16'((kind == K_GOOD) ? DUR_GOOD : (kind == K_BAD) ? DUR_BAD : HALF);
      e.npulse = 8'((kind == K_GLITCH) ? 0 : DB);
      e.data   = m_rx;
      e.ready  = m_ready;
      e.ovr    = m_ovr;
      e.fe     = m_fe;
      exp_q.push_back(e);
    end
    for (int c = 0; c < total; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge tb_clk); #1;
        rst = 1'b0;
        serial_in = 1'b1;
        m_rx = '1; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        @(negedge tb_clk);
        check_reset_values("midframe_rst");
        @(posedge tb_clk); #1;
        return;
      end
      serial_in = line_bit(kind, d, c);
      @(posedge tb_clk); #1;
    end
    serial_in = 1'b1;
    repeat (gap) begin
      @(posedge tb_clk); #1;
    end
  endtask

  task automatic do_read();
    data_read = 1'b1;
    @(posedge tb_clk); #1;
    data_read = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr = 1'b0;
    end
    @(negedge tb_clk);
    check("read_ready", 32'(data_ready), 32'(m_ready));
    check("read_ovr", 32'(overrun_error), 32'(m_ovr));
    @(posedge tb_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, r;
    // reset with the line toggling
    rst = 1'b1;
    repeat (2) begin
      @(posedge tb_clk); #1;
      serial_in = ~serial_in;
    end
    @(negedge tb_clk);
    check_reset_values("reset");
    @(posedge tb_clk); #1;
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (3) begin
      @(posedge tb_clk); #1;
    end

    // directed frames
    send_frame(K_GOOD, 8'hA5, 1 << 30, 0, 4);
    do_read();
    send_frame(K_GLITCH, 8'h00, 1 << 30, 3, CPB + 3);
    send_frame(K_BAD, 8'h3C, 1 << 30, 0, 3);
    send_frame(K_GOOD, 8'h81, 1 << 30, 0, 3);
    do_read();
    send_frame(K_GOOD, 8'h11, 1 << 30, 0, 1);
    send_frame(K_GOOD, 8'h22, 1 << 30, 0, 2);
    do_read();
    do_read();
    send_frame(K_GOOD, 8'h77, 50, 0, 0);
    send_frame(K_GOOD, 8'h5A, 1 << 30, 0, 3);

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 99));
      kind = (r < 70) ? K_GOOD : (r < 85) ? K_BAD : K_GLITCH;
      if (kind == K_GLITCH)
        send_frame(kind, '0, 1 << 30, int'($urandom_range(1, HALF - 1)),
                   CPB + int'($urandom_range(0, 6)));
      else
        send_frame(kind, DB'($urandom), 1 << 30, 0, int'($urandom_range(1, 12)));
      if ($urandom_range(0, 1) == 1) do_read();
    end

    repeat (20) begin
      @(posedge tb_clk); #1;
    end
    check("sb_drain", 32'(exp_q.size()), 32'(0));
    check("stray_pulses", 32'(stray), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
